// File: rtl/debug_dump_tx_if.sv
// Bundle between the dump serializer, the halted datapath debug read ports
// and the UART TX handshake.
interface debug_dump_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int ADDR_WIDTH      = 5
);
    logic                       i_start;
    logic [DATA_WIDTH-1:0]      i_pc;
    logic [ADDR_WIDTH-1:0]      o_reg_addr;
    logic [DATA_WIDTH-1:0]      i_reg_data;
    logic [ADDR_WIDTH-1:0]      o_mem_addr;
    logic [DATA_WIDTH-1:0]      i_mem_data;
    logic [DATA_WIDTH_UART-1:0] o_tx_byte;
    logic                       o_tx_signal;
    logic                       i_tx_done;
    logic                       o_busy;
    logic                       o_done;

    // Serializer side.
    modport slave (
        input  i_start, i_pc, i_reg_data, i_mem_data, i_tx_done,
        output o_reg_addr, o_mem_addr, o_tx_byte, o_tx_signal, o_busy, o_done
    );

    // Host / datapath / UART side.
    modport master (
        output i_start, i_pc, i_reg_data, i_mem_data, i_tx_done,
        input  o_reg_addr, o_mem_addr, o_tx_byte, o_tx_signal, o_busy, o_done
    );
endinterface

// File: rtl/debug_dump_tx.sv
// Debug dump serializer: after a halt, streams PC, the register file and the
// data memory to the UART transmitter, one byte per TX handshake, LSB first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_start; PC latched on acceptance
// SEND    | one-cycle o_tx_signal strobe for the current byte
// WAIT    | byte in flight; advance on i_tx_done
// FETCH   | next word address stable on the debug read port
// CAPTURE | read data captured into the word register
// DONE    | one-cycle o_done pulse after the final byte
module debug_dump_tx #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int NUM_REGS        = 32,
    parameter int NUM_MEM         = 32,
    parameter int ADDR_WIDTH      = 5
) (
    input  logic        i_clock,
    input  logic        i_reset,
    debug_dump_if.slave bus
);
    localparam int LAST_IDX = NUM_REGS + NUM_MEM;
    localparam int WIDX_W   = $clog2(LAST_IDX + 1);
    localparam int BPW      = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int BIDX_W   = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT    = 3'd2,
        FETCH   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [WIDX_W-1:0]          word_idx;
    logic [BIDX_W-1:0]          byte_idx;
    logic [DATA_WIDTH-1:0]      word_reg;
    logic [DATA_WIDTH_UART-1:0] tx_byte;
    logic [ADDR_WIDTH-1:0]      reg_addr;
    logic [ADDR_WIDTH-1:0]      mem_addr;

    logic                       last_byte;
    logic                       last_word;
    logic [BIDX_W-1:0]          byte_nxt;
    logic [WIDX_W-1:0]          word_nxt;
    logic [DATA_WIDTH-1:0]      cap_word;
    logic [DATA_WIDTH_UART-1:0] next_byte;

    assign last_byte = (byte_idx == BIDX_W'(BPW - 1));
    assign last_word = (word_idx == WIDX_W'(LAST_IDX));
    assign byte_nxt  = byte_idx + 1'b1;
    assign word_nxt  = word_idx + 1'b1;
    // Index 1..NUM_REGS come from the register file, the rest from memory.
    assign cap_word  = (word_idx <= WIDX_W'(NUM_REGS)) ? bus.i_reg_data : bus.i_mem_data;
    assign next_byte = word_reg[int'(byte_nxt)*DATA_WIDTH_UART +: DATA_WIDTH_UART];

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; i_tx_done only matters in WAIT, i_start only in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_start) state_nxt = SEND;
            SEND:    state_nxt = WAIT;
            WAIT: begin
                if (bus.i_tx_done) begin
                    if (!last_byte)     state_nxt = SEND;
                    else if (last_word) state_nxt = DONE;
                    else                state_nxt = FETCH;
                end
            end
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word/byte counters, word register, outgoing byte and debug read addresses.
    // The outgoing byte is loaded on every edge that enters SEND so it stays
    // frozen for the whole WAIT regardless of how long the UART takes.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            word_idx <= '0;
            byte_idx <= '0;
            word_reg <= '0;
            tx_byte  <= '0;
            reg_addr <= '0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        word_reg <= bus.i_pc;
                        tx_byte  <= bus.i_pc[DATA_WIDTH_UART-1:0];
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                WAIT: begin
                    if (bus.i_tx_done) begin
                        if (!last_byte) begin
                            byte_idx <= byte_nxt;
                            tx_byte  <= next_byte;
                        end else if (!last_word) begin
                            word_idx <= word_nxt;
                            byte_idx <= '0;
                            if (word_nxt <= WIDX_W'(NUM_REGS)) begin
                                reg_addr <= ADDR_WIDTH'(word_idx);
                            end else begin
                                mem_addr <= ADDR_WIDTH'(word_nxt - WIDX_W'(NUM_REGS + 1));
                            end
                        end
                    end
                end
                CAPTURE: begin
                    word_reg <= cap_word;
                    tx_byte  <= cap_word[DATA_WIDTH_UART-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.o_tx_signal = (state == SEND);
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_done      = (state == DONE);
    assign bus.o_tx_byte   = tx_byte;
    assign bus.o_reg_addr  = reg_addr;
    assign bus.o_mem_addr  = mem_addr;
endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: synchronous register/memory model, UART responder,
// expected-byte queue filled at stimulus time and drained by a monitor.
module tb_debug_dump_tx;
    logic clk;
    logic rst_n;

    debug_dump_if #(.DATA_WIDTH(32), .DATA_WIDTH_UART(8), .ADDR_WIDTH(5)) bus();

    debug_dump_tx dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [32];
    logic [31:0] mems [32];
    logic [7:0]  sb_q [$];
    logic [7:0]  rx [260];
    int          rx_n = 0;
    int          done_cnt = 0;

    int          resp_delay = 3;
    int          stall_byte = 0;
    int          stall_len  = 5000;
    bit          stray_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rx_word(input int w);
        return {rx[4*w+3], rx[4*w+2], rx[4*w+1], rx[4*w]};
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            logic [31:0] t;
            t = w >> (8 * b);
            sb_q.push_back(t[7:0]);
        end
    endtask

    task automatic push_dump(input logic [31:0] pc);
        push_word(pc);
        for (int k = 0; k < 32; k++) push_word(regs[k]);
        for (int k = 0; k < 32; k++) push_word(mems[k]);
    endtask

    // Synchronous debug read ports.
    always @(posedge clk) begin
        bus.i_reg_data <= regs[bus.o_reg_addr];
        bus.i_mem_data <= mems[bus.o_mem_addr];
    end

    // UART responder: done pulse a fixed delay after each strobe, optional
    // long stall on one byte, optional stray pulses in FETCH/CAPTURE.
    initial begin
        int  rcnt;
        int  cnt;
        int  extra;
        bit  pend;
        rcnt = 0; cnt = 0; extra = 0; pend = 1'b0;
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_tx_done = 1'b0;
            if (!rst_n || !bus.o_busy) begin
                pend = 1'b0; extra = 0; rcnt = 0;
            end else if (bus.o_tx_signal) begin
                rcnt++;
                pend = 1'b1;
                cnt  = (rcnt == stall_byte) ? stall_len : resp_delay;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.i_tx_done = 1'b1;
                    pend = 1'b0;
                    if (stray_en && (rcnt % 4 == 0)) extra = 2;
                end
            end else if (extra > 0) begin
                bus.i_tx_done = 1'b1;
                extra--;
            end
        end
    end

    // Monitor: pop and compare on every strobe; check o_done placement.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_tx_signal) begin
                if (sb_q.size() == 0) begin
                    check("extra_strobe", 32'(rx_n + 1), 32'd260);
                end else begin
                    logic [7:0] e;
                    e = sb_q.pop_front();
                    check("tx_byte", {24'd0, bus.o_tx_byte}, {24'd0, e});
                end
                if (rx_n < 260) rx[rx_n] = bus.o_tx_byte;
                rx_n++;
            end
            if (rst_n && bus.o_done) begin
                done_cnt++;
                check("done_after_260", 32'(rx_n), 32'd260);
            end
        end
    end

    task automatic wait_rx(input int target, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rx_n >= target) ok = 1'b1;
        end
        if (!ok) check(name, 32'(rx_n), 32'(target));
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.o_done) ok = 1'b1;
        end
        if (!ok) check(name, 32'd0, 32'd1);
    endtask

    task automatic start_dump(input logic [31:0] pc);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_pc    = pc;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("first_strobe_latency", {31'd0, bus.o_tx_signal}, 32'd1);
        check("busy_after_start", {31'd0, bus.o_busy}, 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_byte"},   {24'd0, bus.o_tx_byte}, 32'd0);
        check({tag, "_tx_signal"}, {31'd0, bus.o_tx_signal}, 32'd0);
        check({tag, "_busy"},      {31'd0, bus.o_busy}, 32'd0);
        check({tag, "_done"},      {31'd0, bus.o_done}, 32'd0);
        check({tag, "_reg_addr"},  {27'd0, bus.o_reg_addr}, 32'd0);
        check({tag, "_mem_addr"},  {27'd0, bus.o_mem_addr}, 32'd0);
    endtask

    initial begin
        logic [7:0] held;
        int         bad;
        for (int k = 0; k < 32; k++) begin
            regs[k] = 32'(k * 3);
            mems[k] = 32'hA5A5_0000 + 32'(k);
        end
        bus.i_start = 1'b0;
        bus.i_pc    = '0;
        rst_n       = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset");

        // Dump 1: PC=0x34, start pulses during word 10 and during DONE.
        push_dump(32'h0000_0034);
        start_dump(32'h0000_0034);
        wait_rx(41, 2000, "timeout_word10");
        bus.i_start = 1'b1;
        bus.i_pc    = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_pc    = '0;
        wait_done(5000, "timeout_done1");
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("busy_falls_after_done", {31'd0, bus.o_busy}, 32'd0);
        check("done_single_cycle", {31'd0, bus.o_done}, 32'd0);
        @(negedge clk);
        check("no_restart_busy", {31'd0, bus.o_busy}, 32'd0);
        check("no_restart_strobe", {31'd0, bus.o_tx_signal}, 32'd0);
        check("dump1_count", 32'(rx_n), 32'd260);
        check("dump1_queue_empty", 32'(sb_q.size()), 32'd0);
        check("dump1_done_cnt", 32'(done_cnt), 32'd1);
        check("final_reg_addr", {27'd0, bus.o_reg_addr}, 32'd31);
        check("final_mem_addr", {27'd0, bus.o_mem_addr}, 32'd31);
        check("word_pc", rx_word(0), 32'h0000_0034);
        check("word_reg31", rx_word(32), 32'd93);
        check("word_mem0", rx_word(33), 32'hA5A5_0000);
        check("word_mem31", rx_word(64), 32'hA5A5_001F);

        // Dump 2: 5000-cycle stall on byte 129, stray dones in FETCH/CAPTURE.
        rx_n       = 0;
        stray_en   = 1'b1;
        stall_byte = 129;
        push_dump(32'h1234_5678);
        start_dump(32'h1234_5678);
        wait_rx(129, 2000, "timeout_byte129");
        @(negedge clk);
        held = bus.o_tx_byte;
        check("stall_byte_value", {24'd0, held}, 32'h5D);
        bad = 0;
        for (int i = 0; i < 4900; i++) begin
            @(negedge clk);
            if (bus.o_tx_signal || bus.o_tx_byte != held) bad++;
        end
        check("stall_hold_violations", 32'(bad), 32'd0);
        wait_done(8000, "timeout_done2");
        @(negedge clk);
        stray_en   = 1'b0;
        stall_byte = 0;
        check("dump2_count", 32'(rx_n), 32'd260);
        check("dump2_done_cnt", 32'(done_cnt), 32'd2);
        check("dump2_queue_empty", 32'(sb_q.size()), 32'd0);
        check("dump2_word_pc", rx_word(0), 32'h1234_5678);

        // Dump 3: asynchronous reset mid-WAIT around byte 70.
        rx_n = 0;
        push_dump(32'h0000_0099);
        start_dump(32'h0000_0099);
        wait_rx(70, 2000, "timeout_byte70");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        sb_q.delete();
        rx_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd2);
        check("abort_idle", {31'd0, bus.o_busy}, 32'd0);

        // Dump 4: restart from PC=8 after the abort.
        push_dump(32'h0000_0008);
        start_dump(32'h0000_0008);
        wait_done(5000, "timeout_done4");
        @(negedge clk);
        check("restart_bytes_0_3", rx_word(0), 32'h0000_0008);
        check("restart_count", 32'(rx_n), 32'd260);
        check("restart_done_cnt", 32'(done_cnt), 32'd3);
        check("restart_queue_empty", 32'(sb_q.size()), 32'd0);
        check("restart_word_mem31", rx_word(64), 32'hA5A5_001F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
